// File: rtl/csla_pkg.sv
// csla_pkg: shared types and constants for the carry-select accumulator
package csla_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
endpackage

// File: rtl/csla_accum_if.sv
// csla_accum_if: operand stream in, burst result out
interface csla_accum_if #(parameter int CNT_W = 8);
  import csla_pkg::*;
  logic in_valid, in_ready, in_last, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_sum;
  logic [CNT_W-1:0] out_ovf_cnt, out_count;
  modport master(output in_valid, in_data, in_last, out_ready,
                 input in_ready, out_valid, out_sum, out_ovf_cnt, out_count);
  modport slave(input in_valid, in_data, in_last, out_ready,
                output in_ready, out_valid, out_sum, out_ovf_cnt, out_count);
endinterface

// File: rtl/csla_accum_csla.sv
// csla_accum_csla: combinational carry-select adder built from B-bit blocks
module csla_accum_csla #(
  parameter int W = 32,
  parameter int B = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W/B:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W/B; i++) begin : g_blk
    logic [B:0] s0, s1;
    // both carry-in candidates are precomputed; the incoming carry only selects
    assign s0 = {1'b0, x[i*B +: B]} + {1'b0, y[i*B +: B]};
    assign s1 = {1'b0, x[i*B +: B]} + {1'b0, y[i*B +: B]} + (B+1)'(1);
    assign s[i*B +: B] = c[i] ? s1[B-1:0] : s0[B-1:0];
    assign c[i+1] = c[i] ? s1[B] : s0[B];
  end
  assign cout = c[W/B];
endmodule

// File: rtl/csla_accum.sv
// csla_accum: bursts of operands summed through a carry-select adder,
// with saturating carry-out and beat counters; result held until taken.
module csla_accum
  import csla_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         rst,
  input logic         clr,
  csla_accum_if.slave bus
);
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] ovf_q, ovf_d, cnt_q, cnt_d;
  logic cout, fire, wipe;
  csla_accum_csla #(.W(DATA_W)) u_csla (
    .x(acc_q), .y(bus.in_data), .cin(1'b0), .s(sum), .cout(cout)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    fire = bus.in_valid & bus.in_ready;
    wipe = clr | (state_q == HOLD & bus.out_ready);
    state_d = clr ? IDLE
            : fire ? (bus.in_last ? HOLD : ACCUM)
            : (state_q == HOLD & bus.out_ready) ? IDLE : state_q;
  end
  always_comb begin
    bus.in_ready    = state_q != HOLD;
    bus.out_valid   = state_q == HOLD;
    bus.out_sum     = acc_q;
    bus.out_ovf_cnt = ovf_q;
    bus.out_count   = cnt_q;
  end
  // clr outranks a beat; a beat cannot coincide with the HOLD handshake
  always_comb begin
    acc_d = wipe ? '0 : fire ? sum : acc_q;
    ovf_d = wipe ? '0 : ovf_q + CNT_W'(fire & cout & (ovf_q != MAX));
    cnt_d = wipe ? '0 : cnt_q + CNT_W'(fire & (cnt_q != MAX));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc_q <= '0;
      ovf_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_csla_accum.sv
// tb_csla_accum: directed bursts checked against a scoreboard of expected results
module tb_csla_accum;
  localparam int CNT_W = 8;
  typedef struct {
    logic [31:0]      s;
    logic [CNT_W-1:0] o;
    logic [CNT_W-1:0] c;
  } exp_t;
  logic clk = 0, rst = 1, clr = 0;
  int vecs = 0, errs = 0;
  exp_t q[$];
  logic [31:0] m_sum = 0;
  logic [CNT_W-1:0] m_ovf = 0, m_cnt = 0;
  csla_accum_if #(.CNT_W(CNT_W)) bus ();
  csla_accum #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .clr(clr), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_sum = 0;
    m_ovf = 0;
    m_cnt = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    logic [32:0] t;
    bus.in_valid = 1;
    bus.in_data  = d;
    bus.in_last  = last;
    #1 chk("in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 0;
    bus.in_last  = 0;
    t = {1'b0, m_sum} + {1'b0, d};
    m_sum = t[31:0];
    if (t[32] && m_ovf != '1) m_ovf++;
    if (m_cnt != '1) m_cnt++;
    if (last) begin
      q.push_back('{m_sum, m_ovf, m_cnt});
      mreset();
    end
  endtask

  task automatic collect(input int hold);
    exp_t e;
    chk("queue", 32'(q.size()), 1);
    if (q.size() == 0) return;
    e = q.pop_front();
    chk("out_valid", 32'(bus.out_valid), 1);
    chk("out_sum", bus.out_sum, e.s);
    chk("out_ovf_cnt", 32'(bus.out_ovf_cnt), 32'(e.o));
    chk("out_count", 32'(bus.out_count), 32'(e.c));
    chk("hold_in_ready", 32'(bus.in_ready), 0);
    bus.out_ready = 0;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1;
      bus.in_data  = 32'h0000_dead;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_sum", bus.out_sum, e.s);
      chk("hold_count", 32'(bus.out_count), 32'(e.c));
      chk("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    bus.out_ready = 0;
    bus.in_valid  = 0;
    chk("done_valid", 32'(bus.out_valid), 0);
    chk("done_sum", bus.out_sum, 0);
    chk("done_ovf", 32'(bus.out_ovf_cnt), 0);
    chk("done_count", 32'(bus.out_count), 0);
    chk("done_in_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    bus.in_valid  = 0;
    bus.in_data   = 0;
    bus.in_last   = 0;
    bus.out_ready = 0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_sum", bus.out_sum, 0);
    chk("rst_count", 32'(bus.out_count), 0);
    #11 rst = 0;
    // three-beat burst, result one cycle after the last beat
    send(1, 0);
    chk("live_sum", bus.out_sum, 1);
    chk("live_valid", 32'(bus.out_valid), 0);
    send(2, 0);
    send(3, 1);
    collect(0);
    // carry-out counted, sum wraps
    send(32'hffff_ffff, 0);
    send(32'h0000_0002, 1);
    collect(0);
    send(32'hffff_ffff, 0);
    send(32'h0000_0001, 1);
    collect(0);
    // single-beat burst held for five cycles
    send(32'h1234_5678, 1);
    collect(5);
    // clr beats a coincident valid beat
    send(5, 0);
    send(7, 0);
    clr = 1;
    bus.in_valid = 1;
    bus.in_data  = 9;
    @(posedge clk);
    #1;
    clr = 0;
    bus.in_valid = 0;
    mreset();
    chk("clr_sum", bus.out_sum, 0);
    chk("clr_count", 32'(bus.out_count), 0);
    chk("clr_ovf", 32'(bus.out_ovf_cnt), 0);
    chk("clr_valid", 32'(bus.out_valid), 0);
    chk("clr_in_ready", 32'(bus.in_ready), 1);
    send(4, 1);
    collect(0);
    // asynchronous reset mid-burst
    send(1, 0);
    send(2, 0);
    #2 rst = 1;
    #1;
    chk("arst_sum", bus.out_sum, 0);
    chk("arst_count", 32'(bus.out_count), 0);
    chk("arst_valid", 32'(bus.out_valid), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    mreset();
    @(posedge clk);
    #3 rst = 0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 32'(bus.out_valid), 0);
    send(10, 1);
    collect(0);
    // counter saturation with continued accumulation
    for (int i = 0; i < 300; i++) send(32'h8000_0000, i == 299);
    chk("sat_exp_count", 32'(q[0].c), 255);
    collect(1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/csla_accum.md
CSLA_ACCUM -- requirements
Module: csla_accum

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the beat counter and the overflow counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port clr, input, 1, synchronous abort of the current burst.
REQ-005 SHALL have port in_valid, input, 1, upstream operand valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts an operand.
REQ-007 SHALL have port in_data, input, 32, operand to accumulate.
REQ-008 SHALL have port in_last, input, 1, marks the final operand of a burst.
REQ-009 SHALL have port out_valid, output, 1, burst result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port out_sum, output, 32, modulo-2^32 sum of the burst.
REQ-012 SHALL have port out_ovf_cnt, output, CNT_W, number of carry-outs that occurred during the burst.
REQ-013 SHALL have port out_count, output, CNT_W, number of operands accepted in the burst.

Function
REQ-014 SHALL implement the states IDLE (no beat accepted), ACCUM (at least one beat accepted, in_last not yet seen) and HOLD (result presented).
REQ-015 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-016 SHALL accept a beat only when in_valid and in_ready are both high at a clock edge.
REQ-017 On each accepted beat, SHALL perform acc <= acc + in_data, truncated to 32 bits, computed by the carry-select adder with cin=0.
REQ-018 On an accepted beat whose adder cout=1, SHALL increment ovf_cnt, saturating at 2^CNT_W-1.
REQ-019 On each accepted beat, SHALL increment count, saturating at 2^CNT_W-1; accumulation continues after count saturates.
REQ-020 On an accepted beat with in_last=0, SHALL go from IDLE to ACCUM, or stay in ACCUM.
REQ-021 On an accepted beat with in_last=1, SHALL go from IDLE or ACCUM to HOLD; a single-beat burst is legal.
REQ-022 Latency: out_valid SHALL rise in the cycle immediately after the edge that accepts the last beat, and out_sum SHALL already include that beat.
REQ-023 In HOLD, out_valid=1 and out_sum, out_ovf_cnt and out_count SHALL stay stable until out_ready=1.
REQ-024 In HOLD with out_ready=1, SHALL go to IDLE and clear acc, ovf_cnt and count to 0.
REQ-025 Outside HOLD, out_valid SHALL be 0; out_sum, out_ovf_cnt and out_count SHALL show the live registers.
REQ-026 clr=1 at an edge SHALL force IDLE and zero all registers; clr has priority over an accepted beat and over out_ready.
REQ-027 Operand wrap-around is silent: for example, 0xFFFFFFFF + 0x00000001 gives acc=0x00000000 and increments ovf_cnt.

Reset
REQ-028 On rst=1, SHALL immediately (asynchronously) set state=IDLE, acc=0, ovf_cnt=0, count=0, out_valid=0 and in_ready=1.
REQ-029 Reset asserted mid-burst or in HOLD SHALL discard the burst, and no result SHALL be emitted after release.
REQ-030 After rst deasserts, the first rising edge of clk SHALL be able to accept a beat.

Structure
REQ-031 The shared package csla_pkg SHALL hold the state enum (IDLE, ACCUM, HOLD) and the constant DATA_W=32.
REQ-032 SHALL instantiate exactly one csla adder (x=acc, y=in_data) as its only sub-module.
REQ-033 The adder SHALL remain combinational, and the acc register SHALL be the only register on the sum path.

Verification
REQ-034 Beats 1, 2, 3 (last on 3), out_ready=1 -> out_valid one cycle after the third beat; out_sum=6, out_ovf_cnt=0, out_count=3; then IDLE.
REQ-035 Beats 0xFFFFFFFF, 0x00000002 (last) -> out_sum=0x00000001, out_ovf_cnt=1, out_count=2.
REQ-036 Single beat 0x12345678 with in_last=1, out_ready held 0 for 5 cycles -> out_valid and out_sum stable for 5 cycles and in_ready=0; handshake on cycle 6.
REQ-037 Beats 5, 7, then clr=1 coincident with a valid beat 9 -> registers zero, IDLE, beat 9 not accumulated; next burst 4 (last) -> out_sum=4.
REQ-038 rst asserted between beats 2 and 3 of a burst -> outputs zero immediately, no out_valid; a following burst 10 (last) -> out_sum=10, out_count=1.
REQ-039 CNT_W=8: 300 beats of 0x80000000 -> out_count=255 (saturated), out_ovf_cnt=150, out_sum=0x00000000.
